time_set_controller: RTL
========================

// Module: time_set_controller
// PURPOSE
// - Producer side of the 4-digit display interface: owns the clock time and drives mode/location/BCD digits consumed by the display driver.
// - Debounces three raw push-buttons, runs a SETUP/RUN state machine and keeps a BCD 24-hour time (HH:MM:SS) from a 1 s prescaler.
// - Sits between board buttons and the display driver; display side only reads its outputs.
// PARAMETERS
// - TICK_DIV         50_000_000  clk cycles per 1 s tick (>=2)
// - DEBOUNCE_CYCLES  1_000_000   cycles a synchronised button must hold a new level before it is accepted (>=1)
// PORTS
// - clk            in   1  system clock, all logic on posedge
// - rst_n          in   1  asynchronous, active-low reset
// - btn_mode       in   1  raw button, active-high: enter/leave SETUP
// - btn_next       in   1  raw button, active-high: advance setup digit
// - btn_inc        in   1  raw button, active-high: increment selected digit
// - mode           out  2  00=SETUP 01=TIME24 10=SECONDS (10 only with macro)
// - location       out  2  digit under edit: 0=hoursUpper 1=hoursLower 2=minutesUpper 3=minutesLower
// - hoursUpper     out  4  BCD 0..2
// - hoursLower     out  4  BCD 0..9 (0..3 when hoursUpper=2)
// - minutesUpper   out  4  BCD 0..5
// - minutesLower   out  4  BCD 0..9
// - sec_tick       out  1  one-cycle pulse on each counted second in RUN
// BEHAVIOUR
// - Reset (async, rst_n=0): mode=00, location=0, all digits and internal seconds=0, prescaler=0, sec_tick=0, debouncers at released level 0.
// - Button path: 2-flop synchroniser -> counter; level accepted after DEBOUNCE_CYCLES consecutive equal samples; counter clears on any mismatch.
// - Press = rising edge of accepted level -> one-cycle pulse; release generates nothing; holding gives exactly one press.
// - Latency: raw edge to output change <= DEBOUNCE_CYCLES+4 cycles.
// - Same-cycle presses: priority mode > next > inc; lower-priority pulses that cycle are dropped.
// - FSM states: SETUP (mode=00), RUN (mode=01); RUN_SEC (mode=10) only with macro.
// - SETUP: prescaler held at 0, seconds held at 0, sec_tick=0.
//   - next: location+1, 3 wraps to 0.
//   - inc: selected digit +1 with wrap: hU 2->0; hL 9->0 (3->0 if hU=2); mU 5->0; mL 9->0.
//   - hU increment to 2 with hL>3: hL forced to 3 in same cycle.
//   - mode press: -> RUN, seconds=0, prescaler=0, location unchanged.
// - RUN: prescaler counts 0..TICK_DIV-1; at TICK_DIV-1 wraps and asserts sec_tick for that one cycle.
//   - tick: seconds BCD 00..59; 59->00 carries minutes; 59 min carries hours; 23:59:59 -> 00:00:00 in one tick.
//   - All digits carried on the same tick update in the same cycle, never an intermediate value.
//   - mode press: -> SETUP, location=0, seconds=0, prescaler=0; a tick coinciding with the press is discarded.
//   - next/inc ignored (next used only with macro).
// - Digit outputs always legal BCD per ranges above; registered, change only on posedge clk.
// - Reset mid-operation (any state, mid-debounce): immediate return to reset values; no press is generated on rst_n release even if a button is held until it is released and pressed again.
// CONFIGURATION
// - SECONDS_VIEW_EN defined: in RUN, next press toggles mode 01<->10 (state RUN<->RUN_SEC); in RUN_SEC minutesUpper/minutesLower carry seconds tens/units, hours unchanged; time keeps counting; mode press from RUN_SEC -> SETUP as from RUN.
// - SECONDS_VIEW_EN undefined: RUN_SEC not built, mode never 10, next ignored in RUN.
// TESTING (TICK_DIV=10, DEBOUNCE_CYCLES=4)
// - Reset then hold btn_mode 20 cycles -> single transition mode 00->01, digits 0000, first sec_tick 10 cycles after entry.
// - Bounce btn_inc high/low every 2 cycles for 20 cycles in SETUP, then release -> no digit change.
// - SETUP: inc hU x2 (=2) with hL preset 7 -> hL=3; inc hL -> 0; next x4 -> location back to 0.
// - Preset 23:59 via SETUP, RUN, 60 ticks -> 00:00 on tick 60, sec_tick pulses 60 times, one cycle each.
// - btn_mode and btn_inc accepted same cycle in SETUP -> mode 01, digits unchanged; rst_n low mid-RUN -> all outputs 0 asynchronously.
// - With SECONDS_VIEW_EN: RUN, 7 ticks, next -> mode=10, minutesUpper=0 minutesLower=7; next -> mode=01 with minutes restored.

Source files
------------

// File: rtl/time_set_controller.sv
// Button-driven 24-hour clock: debounces mode/next/inc, runs SETUP/RUN control and keeps BCD HH:MM:SS.
// Optional macro SECONDS_VIEW_EN adds a RUN_SEC view where the minute digits show seconds.
module time_set_controller #(
    parameter int TICK_DIV        = 50_000_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_mode,
    input  logic       btn_next,
    input  logic       btn_inc,
    output logic [1:0] mode,
    output logic [1:0] location,
    output logic [3:0] hoursUpper,
    output logic [3:0] hoursLower,
    output logic [3:0] minutesUpper,
    output logic [3:0] minutesLower,
    output logic       sec_tick
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int PW = $clog2(TICK_DIV);

`ifdef SECONDS_VIEW_EN
    typedef enum logic [1:0] {SETUP = 2'b00, RUN = 2'b01, RUN_SEC = 2'b10} state_t;
`else
    typedef enum logic [1:0] {SETUP = 2'b00, RUN = 2'b01} state_t;
`endif

    // Debouncers, index 2=mode 1=next 0=inc.
    logic [2:0]    raw, sync1, sync2, stable, armed, press;
    logic [CW-1:0] cnt [3];

    assign raw = {btn_mode, btn_next, btn_inc};

    // Synchronisers reset to "pressed" and armed stays low until a released level
    // is seen, so a button held across reset cannot produce a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 3'b111;
            sync2  <= 3'b111;
            stable <= 3'b000;
            armed  <= 3'b000;
            press  <= 3'b000;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    cnt[i]    <= '0;
                    stable[i] <= sync2[i];
                    press[i]  <= sync2[i] & armed[i];
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
                if (!sync2[i] && !stable[i]) armed[i] <= 1'b1;
            end
        end
    end

    logic p_mode, p_next, p_inc;
    assign p_mode = press[2];
    assign p_next = press[1];
    assign p_inc  = press[0];

    state_t        state, state_n;
    logic [1:0]    loc, loc_n;
    logic [3:0]    hu, hl, mu, ml, st, su;
    logic [3:0]    hu_n, hl_n, mu_n, ml_n, st_n, su_n;
    logic [PW-1:0] presc, presc_n;
    logic          tick;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SETUP;
            loc   <= 2'd0;
            hu    <= 4'd0;
            hl    <= 4'd0;
            mu    <= 4'd0;
            ml    <= 4'd0;
            st    <= 4'd0;
            su    <= 4'd0;
            presc <= '0;
        end else begin
            state <= state_n;
            loc   <= loc_n;
            hu    <= hu_n;
            hl    <= hl_n;
            mu    <= mu_n;
            ml    <= ml_n;
            st    <= st_n;
            su    <= su_n;
            presc <= presc_n;
        end
    end

    always_comb begin
        state_n = state;
        loc_n   = loc;
        hu_n    = hu;
        hl_n    = hl;
        mu_n    = mu;
        ml_n    = ml;
        st_n    = st;
        su_n    = su;
        presc_n = presc;
        tick    = 1'b0;
        case (state)
            SETUP: begin
                presc_n = '0;
                st_n    = 4'd0;
                su_n    = 4'd0;
                if (p_mode) begin
                    state_n = RUN;
                end else if (p_next) begin
                    loc_n = loc + 2'd1;
                end else if (p_inc) begin
                    case (loc)
                        2'd0: begin
                            if (hu == 4'd2) begin
                                hu_n = 4'd0;
                            end else begin
                                hu_n = hu + 4'd1;
                                if (hu == 4'd1 && hl > 4'd3) hl_n = 4'd3;
                            end
                        end
                        2'd1:    hl_n = (hl == 4'd9 || (hu == 4'd2 && hl == 4'd3)) ? 4'd0 : hl + 4'd1;
                        2'd2:    mu_n = (mu == 4'd5) ? 4'd0 : mu + 4'd1;
                        default: ml_n = (ml == 4'd9) ? 4'd0 : ml + 4'd1;
                    endcase
                end
            end
            default: begin
                presc_n = (presc == PW'(TICK_DIV - 1)) ? '0 : presc + PW'(1);
                if (p_mode) begin
                    state_n = SETUP;
                    loc_n   = 2'd0;
                    st_n    = 4'd0;
                    su_n    = 4'd0;
                    presc_n = '0;
                end else begin
`ifdef SECONDS_VIEW_EN
                    if (p_next) state_n = (state == RUN) ? RUN_SEC : RUN;
`endif
                    // One tick resolves the full carry chain in a single update.
                    if (presc == PW'(TICK_DIV - 1)) begin
                        tick = 1'b1;
                        if (su != 4'd9) begin
                            su_n = su + 4'd1;
                        end else begin
                            su_n = 4'd0;
                            if (st != 4'd5) begin
                                st_n = st + 4'd1;
                            end else begin
                                st_n = 4'd0;
                                if (ml != 4'd9) begin
                                    ml_n = ml + 4'd1;
                                end else begin
                                    ml_n = 4'd0;
                                    if (mu != 4'd5) begin
                                        mu_n = mu + 4'd1;
                                    end else begin
                                        mu_n = 4'd0;
                                        if (hu == 4'd2 && hl == 4'd3) begin
                                            hu_n = 4'd0;
                                            hl_n = 4'd0;
                                        end else if (hl == 4'd9) begin
                                            hl_n = 4'd0;
                                            hu_n = hu + 4'd1;
                                        end else begin
                                            hl_n = hl + 4'd1;
                                        end
                                    end
                                end
                            end
                        end
                    end
                end
            end
        endcase
    end

    assign mode       = state;
    assign location   = loc;
    assign hoursUpper = hu;
    assign hoursLower = hl;
    assign sec_tick   = tick;
`ifdef SECONDS_VIEW_EN
    assign minutesUpper = (state == RUN_SEC) ? st : mu;
    assign minutesLower = (state == RUN_SEC) ? su : ml;
`else
    assign minutesUpper = mu;
    assign minutesLower = ml;
`endif

endmodule
